// File: rtl/jtobj_zscan_if.sv
// Draw-command bus between the zoomed-sprite scanner FIFO head and the tile drawer.
// The scanner (master) presents the FIFO head; the drawer (slave) pops with ready.
interface jtobj_zscan_if;
  logic        valid;
  logic        ready;
  logic [15:0] code;
  logic [8:0]  hpos;
  logic [3:0]  ysub;
  logic [7:0]  hzoom;
  logic        hflip;

  modport master (output valid, code, hpos, ysub, hzoom, hflip, input ready);
  modport slave  (input valid, code, hpos, ysub, hzoom, hflip, output ready);
endinterface

// File: rtl/jtobj_zscan.sv
// Zoomed-sprite line scanner: walks the object table per line and queues one command per tile.
// Define JTOBJ_ZSCAN_REVERSE_EN to scan the table from the last entry down to 0.
module jtobj_zscan #(
  parameter int unsigned OBJW    = 8,
  parameter int unsigned FIFO_AW = 3,
  parameter int unsigned MAXOBJ  = 32
) (
  input  logic            rst,
  input  logic            clk,
  input  logic            cen,
  input  logic            line_start,
  input  logic [8:0]      vline,
  output logic [OBJW+1:0] tbl_addr,
  input  logic [15:0]     tbl_data,
  jtobj_zscan_if.master   cmd,
  output logic            scan_busy,
  output logic            line_ovf,
  output logic            line_miss
);

  typedef enum logic [2:0] {StIdle, StFetch, StCalc, StEmit, StDone} state_e;

  localparam int unsigned CW    = $clog2(MAXOBJ + 1);
  localparam int unsigned DEPTH = 2 ** FIFO_AW;
  localparam logic [CW-1:0]      CNT_MAX = CW'(MAXOBJ);
  localparam logic [CW-1:0]      CNT_ONE = CW'(1);
  localparam logic [OBJW-1:0]    OBJ_ONE = OBJW'(1);
  localparam logic [FIFO_AW:0]   PTR_ONE = (FIFO_AW + 1)'(1);
`ifdef JTOBJ_ZSCAN_REVERSE_EN
  localparam logic [OBJW-1:0]    OBJ_FIRST = '1;
  localparam logic [OBJW-1:0]    OBJ_LAST  = '0;
`else
  localparam logic [OBJW-1:0]    OBJ_FIRST = '0;
  localparam logic [OBJW-1:0]    OBJ_LAST  = '1;
`endif

  state_e          state;
  logic            calc_ph;
  logic [1:0]      wrd;
  logic [OBJW-1:0] obj, obj_next;
  logic [CW-1:0]   cnt;
  logic [8:0]      vline_l, y, x, ydiff, hpos;
  logic            hflip, vflip, busy, in_zone;
  logic [1:0]      vsz, hsz;
  logic [15:0]     code, code_t, code_v;
  logic [7:0]      hzoom, vzoom;
  logic [16:0]     mul;
  logic [10:0]     scaled, scaled_n;
  logic [2:0]      step, vmask, hmask, t, h, fv, fh;
  logic [3:0]      ysub, ysub_n;
  logic [37:0]     mem [DEPTH];
  logic [FIFO_AW:0] wp, rp;
  logic            full, empty, push, pop, flush;

`ifdef JTOBJ_ZSCAN_REVERSE_EN
  assign obj_next = obj - OBJ_ONE;
`else
  assign obj_next = obj + OBJ_ONE;
`endif

  assign busy      = (state == StFetch) || (state == StCalc) || (state == StEmit);
  assign scan_busy = busy;

  assign ydiff    = vline_l - y;
  assign mul      = 17'(ydiff) * 17'(vzoom);
  assign scaled_n = 11'(mul >> 6);
  assign vmask    = 3'((4'd1 << vsz) - 4'd1);
  assign hmask    = 3'((4'd1 << hsz) - 4'd1);
  assign in_zone  = ~ydiff[8] && (scaled < (11'd16 << vsz));
  assign t        = (scaled[6:4] ^ (vflip ? vmask : 3'd0)) & vmask;
  assign ysub_n   = scaled[3:0] ^ {4{vflip}};

  // Vertical tile index goes into code bits {5,3,1}, horizontal into {4,2,0}; no carry out.
  assign fv     = {code[5], code[3], code[1]} + t;
  assign code_t = {code[15:6], fv[2], code[4], fv[1], code[2], fv[0], code[0]};
  assign h      = (step ^ (hflip ? hmask : 3'd0)) & hmask;
  assign fh     = {code[4], code[2], code[0]} + h;
  assign code_v = {code[15:6], code[5], fh[2], code[3], fh[1], code[1], fh[0]};
  assign hpos   = x + {2'b00, step, 4'b0000};

  assign empty = (wp == rp);
  assign full  = (wp[FIFO_AW] != rp[FIFO_AW]) && (wp[FIFO_AW-1:0] == rp[FIFO_AW-1:0]);
  assign flush = cen & line_start & busy;
  assign pop   = cen & ~empty & cmd.ready;
  assign push  = cen & ~line_start & (state == StEmit) & (~full | pop);

  assign cmd.valid = ~empty;
  assign {cmd.code, cmd.hpos, cmd.ysub, cmd.hzoom, cmd.hflip} =
      empty ? 38'd0 : mem[rp[FIFO_AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) begin
        mem[wp[FIFO_AW-1:0]] <= {code_v, hpos, ysub, hzoom, hflip};
        wp <= wp + PTR_ONE;
      end
      if (pop) rp <= rp + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= StIdle;  calc_ph <= 1'b0; wrd <= '0;  obj <= '0;    cnt <= '0;
      vline_l <= '0;    tbl_addr <= '0;  y <= '0;    x <= '0;      hflip <= 1'b0;
      vflip <= 1'b0;    vsz <= '0;       hsz <= '0;  code <= '0;   hzoom <= '0;
      vzoom <= '0;      scaled <= '0;    step <= '0; ysub <= '0;
      line_ovf <= 1'b0; line_miss <= 1'b0;
    end else if (cen) begin
      if (line_start) begin
        vline_l   <= vline;
        obj       <= OBJ_FIRST;
        tbl_addr  <= {OBJ_FIRST, 2'd0};
        wrd       <= 2'd0;
        cnt       <= '0;
        line_ovf  <= 1'b0;
        line_miss <= busy;
        state     <= StFetch;
      end else begin
        unique case (state)
          StFetch: begin
            unique case (wrd)
              2'd0: begin
                {hflip, vflip, vsz, hsz, y} <= tbl_data[14:0];
                if (tbl_data[15]) begin
                  tbl_addr <= {obj, 2'd1};
                  wrd      <= 2'd1;
                end else if (obj == OBJ_LAST) begin
                  state <= StDone;
                end else begin
                  obj      <= obj_next;
                  tbl_addr <= {obj_next, 2'd0};
                end
              end
              2'd1: begin
                code     <= tbl_data;
                tbl_addr <= {obj, 2'd2};
                wrd      <= 2'd2;
              end
              2'd2: begin
                x        <= tbl_data[8:0];
                tbl_addr <= {obj, 2'd3};
                wrd      <= 2'd3;
              end
              2'd3: begin
                {hzoom, vzoom} <= tbl_data;
                wrd     <= 2'd0;
                calc_ph <= 1'b0;
                state   <= StCalc;
              end
            endcase
          end
          StCalc: begin
            calc_ph <= ~calc_ph;
            if (!calc_ph) begin
              scaled <= scaled_n;
            end else if (in_zone) begin
              code  <= code_t;
              ysub  <= ysub_n;
              step  <= 3'd0;
              cnt   <= cnt + CNT_ONE;
              state <= StEmit;
            end else if (obj == OBJ_LAST) begin
              state <= StDone;
            end else begin
              obj      <= obj_next;
              tbl_addr <= {obj_next, 2'd0};
              state    <= StFetch;
            end
          end
          StEmit: begin
            if (push) begin
              step <= step + 3'd1;
              if (step == hmask) begin
                if (cnt == CNT_MAX) begin
                  line_ovf <= 1'b1;
                  state    <= StDone;
                end else if (obj == OBJ_LAST) begin
                  state <= StDone;
                end else begin
                  obj      <= obj_next;
                  tbl_addr <= {obj_next, 2'd0};
                  state    <= StFetch;
                end
              end
            end
          end
          StDone:  state <= StIdle;
          StIdle:  state <= StIdle;
          default: state <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_jtobj_zscan.sv
// Self-checking bench for jtobj_zscan: directed scenarios plus randomized tables,
// each line checked against a per-object arithmetic reference model.
`timescale 1ns/1ps
module tb_jtobj_zscan;
  localparam int OBJW    = 8;
  localparam int FIFO_AW = 3;
  localparam int MAXOBJ  = 32;
  localparam int NOBJ    = 1 << OBJW;
  localparam int NW      = NOBJ * 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            cen = 1'b1;
  logic            line_start = 1'b0;
  logic [8:0]      vline = '0;
  logic [OBJW+1:0] tbl_addr;
  logic [15:0]     tbl_data;
  logic            scan_busy, line_ovf, line_miss;

  jtobj_zscan_if cmd_if ();

  logic [15:0] mem [NW];
  logic [37:0] got_q[$];
  logic [37:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          exp_ovf;
  bit          rnd_mode = 1'b0;
  bit          ready_fix = 1'b1;

  always #5 clk = ~clk;
  assign tbl_data = mem[tbl_addr];

  jtobj_zscan #(.OBJW(OBJW), .FIFO_AW(FIFO_AW), .MAXOBJ(MAXOBJ)) dut (
    .rst        (rst),
    .clk        (clk),
    .cen        (cen),
    .line_start (line_start),
    .vline      (vline),
    .tbl_addr   (tbl_addr),
    .tbl_data   (tbl_data),
    .cmd        (cmd_if),
    .scan_busy  (scan_busy),
    .line_ovf   (line_ovf),
    .line_miss  (line_miss)
  );

  always @(negedge clk)
    if (!rst && cen && cmd_if.valid && cmd_if.ready)
      got_q.push_back({cmd_if.code, cmd_if.hpos, cmd_if.ysub, cmd_if.hzoom, cmd_if.hflip});

  always @(posedge clk) begin
    #2;
    cen          = rnd_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
    cmd_if.ready = rnd_mode ? 1'($urandom_range(0, 1)) : ready_fix;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [37:0] pk(logic [15:0] c, logic [8:0] hp, logic [3:0] ys,
                                     logic [7:0] hz, logic hf);
    return {c, hp, ys, hz, hf};
  endfunction

  function automatic logic [37:0] got_at(int i);
    return (i < got_q.size()) ? got_q[i] : 38'bx;
  endfunction

  // Adds v (mod 8) to the 3-bit field spread over code bits off, off+2, off+4.
  function automatic logic [15:0] add_fld(logic [15:0] c, int off, int v);
    int f;
    logic [15:0] r;
    f = int'(c[off]) + 2 * int'(c[off+2]) + 4 * int'(c[off+4]);
    f = (f + v) % 8;
    r = c;
    r[off] = f[0]; r[off+2] = f[1]; r[off+4] = f[2];
    return r;
  endfunction

  task automatic model_line(input int vl);
    int k, ydiff, scaled, nt, nh, vt, ys, h, cnt;
    logic [15:0] w0, w1, w2, w3, c;
    exp_q.delete();
    exp_ovf = 0;
    cnt = 0;
    for (int i = 0; i < NOBJ; i++) begin
`ifdef JTOBJ_ZSCAN_REVERSE_EN
      k = NOBJ - 1 - i;
`else
      k = i;
`endif
      w0 = mem[4*k]; w1 = mem[4*k+1]; w2 = mem[4*k+2]; w3 = mem[4*k+3];
      if (!w0[15]) continue;
      ydiff = (vl - int'(w0[8:0])) & 511;
      if (ydiff >= 256) continue;
      scaled = (ydiff * int'(w3[7:0])) / 64;
      nt = 1 << w0[12:11];
      if (scaled >= 16 * nt) continue;
      vt = scaled / 16;
      ys = scaled % 16;
      if (w0[13]) begin
        vt = nt - 1 - vt;
        ys = 15 - ys;
      end
      c  = add_fld(w1, 1, vt);
      nh = 1 << w0[10:9];
      for (int s = 0; s < nh; s++) begin
        h = w0[14] ? nh - 1 - s : s;
        exp_q.push_back({add_fld(c, 0, h), 9'((int'(w2[8:0]) + 16 * s) % 512), 4'(ys),
                         w3[15:8], w0[14]});
      end
      cnt++;
      if (cnt == MAXOBJ) begin
        exp_ovf = 1;
        break;
      end
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < NW; i++) mem[i] = 16'h0;
  endtask

  task automatic put_obj(int k, logic hf, logic vf, logic [1:0] vsz, logic [1:0] hsz,
                         logic [8:0] y, logic [15:0] c, logic [8:0] x, logic [7:0] hz,
                         logic [7:0] vz);
    mem[4*k]   = {1'b1, hf, vf, vsz, hsz, y};
    mem[4*k+1] = c;
    mem[4*k+2] = {7'b0, x};
    mem[4*k+3] = {hz, vz};
  endtask

  task automatic start_line(input logic [8:0] v);
    bit ok;
    vline = v;
    line_start = 1'b1;
    do begin
      @(posedge clk);
      ok = cen;
      #1;
    end while (!ok);
    line_start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((scan_busy || cmd_if.valid) && n < 20000) begin
      tick();
      n++;
    end
    checks++;
    if (scan_busy || cmd_if.valid) begin
      errors++;
      $display("FAIL %s idle: busy=%0d valid=%0d after %0d cycles, required 0/0",
               name, scan_busy, cmd_if.valid, n);
    end
  endtask

  task automatic compare_q(input string name);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s count: got %0d commands, required %0d", name, got_q.size(),
               exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (got_at(i) !== exp_q[i]) begin
        errors++;
        $display("FAIL %s cmd[%0d]: got %h, required %h", name, i, got_at(i), exp_q[i]);
      end
    end
    checks++;
    if (line_ovf !== 1'(exp_ovf)) begin
      errors++;
      $display("FAIL %s line_ovf: got %0d, required %0d", name, line_ovf, exp_ovf);
    end
  endtask

  task automatic run_line(input logic [8:0] v, input string name);
    got_q.delete();
    model_line(int'(v));
    start_line(v);
    wait_idle(name);
    compare_q(name);
  endtask

  task automatic test_reset();
    repeat (4) tick();
    rst = 1'b0;
    tick();
    checks++;
    if ({tbl_addr, scan_busy, line_ovf, line_miss} !== '0) begin
      errors++;
      $display("FAIL reset status: got addr=%h busy=%0d ovf=%0d miss=%0d, required all 0",
               tbl_addr, scan_busy, line_ovf, line_miss);
    end
    checks++;
    if ({cmd_if.valid, cmd_if.code, cmd_if.hpos, cmd_if.ysub, cmd_if.hzoom, cmd_if.hflip}
        !== '0) begin
      errors++;
      $display("FAIL reset cmd: got valid=%0d code=%h, required all 0", cmd_if.valid,
               cmd_if.code);
    end
  endtask

  task automatic test_single();
    clear_mem();
    put_obj(0, 1'b0, 1'b0, 2'd0, 2'd1, 9'h020, 16'h0100, 9'h080, 8'h40, 8'h40);
    run_line(9'h025, "single");
    checks++;
    if (got_at(0) !== pk(16'h0100, 9'h080, 4'd5, 8'h40, 1'b0)) begin
      errors++;
      $display("FAIL single first: got %h, required code 0100 hpos 080 ysub 5", got_at(0));
    end
    checks++;
    if (got_at(1) !== pk(16'h0101, 9'h090, 4'd5, 8'h40, 1'b0)) begin
      errors++;
      $display("FAIL single second: got %h, required code 0101 hpos 090 ysub 5", got_at(1));
    end
  endtask

  task automatic test_vzoom();
    clear_mem();
    put_obj(0, 1'b0, 1'b0, 2'd0, 2'd1, 9'h020, 16'h0100, 9'h080, 8'h40, 8'h80);
    run_line(9'h028, "vzoom_out");
    checks++;
    if (got_q.size() != 0) begin
      errors++;
      $display("FAIL vzoom_out count: got %0d, required 0", got_q.size());
    end
    run_line(9'h027, "vzoom_in");
    checks++;
    if (got_at(0) !== pk(16'h0100, 9'h080, 4'd14, 8'h40, 1'b0)) begin
      errors++;
      $display("FAIL vzoom_in ysub: got %h, required ysub 14", got_at(0));
    end
  endtask

  task automatic test_vflip();
    clear_mem();
    put_obj(0, 1'b0, 1'b1, 2'd1, 2'd0, 9'h020, 16'h0100, 9'h080, 8'h40, 8'h40);
    run_line(9'h034, "vflip");
    checks++;
    if (got_at(0) !== pk(16'h0100, 9'h080, 4'd11, 8'h40, 1'b0)) begin
      errors++;
      $display("FAIL vflip cmd: got %h, required code 0100 ysub 11", got_at(0));
    end
  endtask

  task automatic test_maxobj();
    clear_mem();
    for (int k = 0; k < MAXOBJ + 4; k++)
      put_obj(k, 1'b0, 1'b0, 2'd0, 2'd0, 9'h010, 16'(k * 64), 9'h040, 8'h40, 8'h40);
    run_line(9'h012, "maxobj");
    checks++;
    if (got_q.size() != MAXOBJ || line_ovf !== 1'b1) begin
      errors++;
      $display("FAIL maxobj cut: got %0d cmds ovf=%0d, required %0d cmds ovf=1",
               got_q.size(), line_ovf, MAXOBJ);
    end
  endtask

  task automatic test_stall();
    clear_mem();
    for (int k = 0; k < 3; k++)
      put_obj(k, 1'(k == 1), 1'b0, 2'd0, 2'd2, 9'h100, 16'($urandom), 9'($urandom),
              8'($urandom), 8'h40);
    ready_fix = 1'b0;
    repeat (2) tick();
    got_q.delete();
    model_line(9'h105);
    start_line(9'h105);
    repeat (100) tick();
    checks++;
    if (!(scan_busy === 1'b1 && cmd_if.valid === 1'b1)) begin
      errors++;
      $display("FAIL stall hold: got busy=%0d valid=%0d, required 1/1", scan_busy,
               cmd_if.valid);
    end
    ready_fix = 1'b1;
    wait_idle("stall");
    compare_q("stall");
  endtask

  task automatic test_miss();
    clear_mem();
    for (int k = 0; k < 64; k++)
      put_obj(k, 1'b0, 1'b0, 2'd0, 2'd0, 9'h040, 16'(k * 3), 9'($urandom), 8'h40, 8'h40);
    ready_fix = 1'b0;
    repeat (2) tick();
    start_line(9'h042);
    repeat (19) tick();
    start_line(9'h045);
    got_q.delete();
    model_line(9'h045);
    ready_fix = 1'b1;
    wait_idle("miss");
    compare_q("miss");
    checks++;
    if (line_miss !== 1'b1) begin
      errors++;
      $display("FAIL miss flag: got %0d, required 1", line_miss);
    end
    run_line(9'h046, "miss_clean");
    checks++;
    if (line_miss !== 1'b0) begin
      errors++;
      $display("FAIL miss clear: got %0d, required 0", line_miss);
    end
  endtask

  task automatic test_random();
    int vl, den;
    rnd_mode = 1'b1;
    for (int it = 0; it < 6; it++) begin
      vl  = $urandom_range(0, 511);
      den = $urandom_range(2, 16);
      for (int k = 0; k < NOBJ; k++) begin
        mem[4*k]   = {1'($urandom_range(0, den - 1) == 0), 6'($urandom),
                      9'(vl - $urandom_range(0, 60))};
        mem[4*k+1] = 16'($urandom);
        mem[4*k+2] = {7'b0, 9'($urandom)};
        mem[4*k+3] = 16'($urandom);
      end
      run_line(9'(vl), "random");
      checks++;
      if (line_miss !== 1'b0) begin
        errors++;
        $display("FAIL random miss: got %0d, required 0", line_miss);
      end
    end
    rnd_mode = 1'b0;
  endtask

  initial begin
    clear_mem();
    test_reset();
    test_single();
    test_vzoom();
    test_vflip();
    test_maxobj();
    test_stall();
    test_miss();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
